// File: rtl/fpu_issue_wire.sv
// rtl/fpu_issue_wire.sv - shared op codes, FSM states, rounding-mode and flag constants
package fpu_issue_wire;

    typedef enum logic [4:0] {
        FADD     = 5'd0,
        FSUB     = 5'd1,
        FMUL     = 5'd2,
        FDIV     = 5'd3,
        FSQRT    = 5'd4,
        FSGNJ    = 5'd5,
        FMINMAX  = 5'd6,
        FCMP     = 5'd7,
        FMV_F2I  = 5'd8,
        FMV_I2F  = 5'd9,
        FCLASS   = 5'd10,
        FCVT_F2I = 5'd11,
        FCVT_I2F = 5'd12,
        FMADD    = 5'd13,
        FMSUB    = 5'd14,
        FNMSUB   = 5'd15,
        FNMADD   = 5'd16
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_EXEC = 3'd1,
        ST_WAIT = 3'd2,
        ST_WB   = 3'd3,
        ST_ILL  = 3'd4,
        ST_ERR  = 3'd5
    } state_e;

    localparam logic [2:0] RM_RNE  = 3'd0;
    localparam logic [2:0] RM_RTZ  = 3'd1;
    localparam logic [2:0] RM_RDN  = 3'd2;
    localparam logic [2:0] RM_RUP  = 3'd3;
    localparam logic [2:0] RM_RMM  = 3'd4;
    localparam logic [2:0] RM_RSV5 = 3'd5;
    localparam logic [2:0] RM_RSV6 = 3'd6;
    localparam logic [2:0] RM_DYN  = 3'd7;

    localparam int FLAG_NX = 0;
    localparam int FLAG_UF = 1;
    localparam int FLAG_OF = 2;
    localparam int FLAG_DZ = 3;
    localparam int FLAG_NV = 4;

    // Sign-injection, raw moves and classify never raise IEEE exceptions.
    function automatic logic op_sets_flags(input logic [4:0] op);
        return !((op == FSGNJ) || (op == FMV_F2I) || (op == FMV_I2F) || (op == FCLASS));
    endfunction

endpackage

// File: rtl/fpu_rm_resolve.sv
// rtl/fpu_rm_resolve.sv - dynamic rounding-mode substitution and legality check
module fpu_rm_resolve
    import fpu_issue_wire::*;
(
    input  logic [2:0] rm,
    input  logic [2:0] frm,
    output logic [2:0] rm_eff,
    output logic       illegal
);

    assign rm_eff  = (rm == RM_DYN) ? frm : rm;
    assign illegal = (rm_eff == RM_RSV5) || (rm_eff == RM_RSV6);

endmodule

// File: rtl/fpu_issue_ctrl.sv
// rtl/fpu_issue_ctrl.sv - FPU issue/writeback sequencer; FPU_FFLAGS_ACCUM_EN adds sticky flag accumulator
module fpu_issue_ctrl
    import fpu_issue_wire::*;
#(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [4:0]  req_op,
    input  logic [2:0]  req_rm,
    input  logic        req_fdest,
    input  logic [4:0]  req_waddr,
    input  logic [31:0] req_data1,
    input  logic [31:0] req_data2,
    input  logic [31:0] req_data3,
    input  logic [2:0]  frm,
    input  logic        flush,
    output logic        exe_enable,
    output logic        exe_kill,
    output logic [4:0]  exe_op,
    output logic [2:0]  exe_rm,
    output logic [31:0] exe_data1,
    output logic [31:0] exe_data2,
    output logic [31:0] exe_data3,
    input  logic        exe_ready,
    input  logic [31:0] exe_result,
    input  logic [4:0]  exe_flags,
    output logic        wb_fwren,
    output logic        wb_wren,
    output logic [4:0]  wb_waddr,
    output logic [31:0] wb_wdata,
    output logic        wb_flag_en,
    output logic [4:0]  wb_fflags,
    output logic        wb_illegal,
    output logic        wb_error,
    input  logic        acc_clear,
    output logic [4:0]  acc_fflags
);

    state_e           state;
    logic [CNT_W-1:0] cnt;
    logic             fdest_q;
    logic [2:0]       rm_eff;
    logic             rm_illegal;
    logic             can_accept;
    logic             accept;
    logic             in_flight;
    logic             timeout_hit;

    fpu_rm_resolve u_rm_resolve (
        .rm      (req_rm),
        .frm     (frm),
        .rm_eff  (rm_eff),
        .illegal (rm_illegal)
    );

    // WB/ILL/ERR all accept so a new op can issue in the cycle after a completion.
    assign can_accept  = (state == ST_IDLE) || (state == ST_WB) ||
                         (state == ST_ILL)  || (state == ST_ERR);
    assign req_ready   = can_accept && !flush;
    assign accept      = req_valid && req_ready;
    assign in_flight   = (state == ST_EXEC) || (state == ST_WAIT);
    assign timeout_hit = (state == ST_WAIT) && !exe_ready && (cnt == CNT_W'(TIMEOUT - 1));

    assign exe_enable  = (state == ST_EXEC);
    assign exe_kill    = in_flight && (flush || timeout_hit);

    // flush in a completion cycle cancels that cycle's strobes.
    assign wb_fwren    = (state == ST_WB) && !flush && fdest_q;
    assign wb_wren     = (state == ST_WB) && !flush && !fdest_q && (wb_waddr != 5'd0);
    assign wb_flag_en  = (state == ST_WB) && !flush && op_sets_flags(exe_op);
    assign wb_illegal  = (state == ST_ILL) && !flush;
    assign wb_error    = (state == ST_ERR) && !flush;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            fdest_q   <= 1'b0;
            exe_op    <= 5'd0;
            exe_rm    <= 3'd0;
            exe_data1 <= 32'd0;
            exe_data2 <= 32'd0;
            exe_data3 <= 32'd0;
            wb_waddr  <= 5'd0;
            wb_wdata  <= 32'd0;
            wb_fflags <= 5'd0;
        end else begin
            unique case (state)
                ST_IDLE, ST_WB, ST_ILL, ST_ERR: begin
                    if (accept) begin
                        exe_op    <= req_op;
                        exe_rm    <= rm_eff;
                        exe_data1 <= req_data1;
                        exe_data2 <= req_data2;
                        exe_data3 <= req_data3;
                        fdest_q   <= req_fdest;
                        wb_waddr  <= req_waddr;
                        state     <= rm_illegal ? ST_ILL : ST_EXEC;
                    end else begin
                        state     <= ST_IDLE;
                    end
                end
                ST_EXEC: begin
                    cnt <= '0;
                    if (flush) begin
                        state <= ST_IDLE;
                    end else if (exe_ready) begin
                        wb_wdata  <= exe_result;
                        wb_fflags <= exe_flags;
                        state     <= ST_WB;
                    end else begin
                        state     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (flush) begin
                        state <= ST_IDLE;
                    end else if (exe_ready) begin
                        wb_wdata  <= exe_result;
                        wb_fflags <= exe_flags;
                        state     <= ST_WB;
                    end else if (timeout_hit) begin
                        state <= ST_ERR;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef FPU_FFLAGS_ACCUM_EN
    logic [4:0] acc_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc_q <= 5'd0;
        end else if (acc_clear) begin
            acc_q <= 5'd0;
        end else if (wb_flag_en) begin
            acc_q <= acc_q | wb_fflags;
        end
    end

    assign acc_fflags = acc_q;
`else
    logic unused_acc_clear;

    assign unused_acc_clear = acc_clear;
    assign acc_fflags       = 5'd0;
`endif

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// tb/tb_fpu_issue_ctrl.sv - directed, cycle-scheduled bench for fpu_issue_ctrl
module tb_fpu_issue_ctrl;
    import fpu_issue_wire::*;

    localparam int NCYC = 125;
    localparam int TMO  = 64;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [4:0]  req_op = '0;
    logic [2:0]  req_rm = '0;
    logic        req_fdest = 1'b0;
    logic [4:0]  req_waddr = '0;
    logic [31:0] req_data1 = '0, req_data2 = '0, req_data3 = '0;
    logic [2:0]  frm = '0;
    logic        flush = 1'b0;
    logic        exe_enable, exe_kill;
    logic [4:0]  exe_op;
    logic [2:0]  exe_rm;
    logic [31:0] exe_data1, exe_data2, exe_data3;
    logic        exe_ready = 1'b0;
    logic [31:0] exe_result = '0;
    logic [4:0]  exe_flags = '0;
    logic        wb_fwren, wb_wren, wb_flag_en, wb_illegal, wb_error;
    logic [4:0]  wb_waddr, wb_fflags;
    logic [31:0] wb_wdata;
    logic        acc_clear = 1'b0;
    logic [4:0]  acc_fflags;

    fpu_issue_ctrl #(.TIMEOUT(TMO), .CNT_W(7)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_rm(req_rm),
        .req_fdest(req_fdest), .req_waddr(req_waddr),
        .req_data1(req_data1), .req_data2(req_data2), .req_data3(req_data3),
        .frm(frm), .flush(flush),
        .exe_enable(exe_enable), .exe_kill(exe_kill), .exe_op(exe_op), .exe_rm(exe_rm),
        .exe_data1(exe_data1), .exe_data2(exe_data2), .exe_data3(exe_data3),
        .exe_ready(exe_ready), .exe_result(exe_result), .exe_flags(exe_flags),
        .wb_fwren(wb_fwren), .wb_wren(wb_wren), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
        .wb_flag_en(wb_flag_en), .wb_fflags(wb_fflags),
        .wb_illegal(wb_illegal), .wb_error(wb_error),
        .acc_clear(acc_clear), .acc_fflags(acc_fflags)
    );

    always #5 clock = ~clock;

    // Input schedule, indexed by cycle
    bit          d_valid[NCYC], d_fdest[NCYC], d_rdy[NCYC], d_flush[NCYC], d_clr[NCYC];
    logic [4:0]  d_op[NCYC], d_waddr[NCYC], d_flg[NCYC];
    logic [2:0]  d_rm[NCYC], d_frm[NCYC];
    logic [31:0] d_res[NCYC];
    // Expected outputs, indexed by cycle
    bit          e_rdy[NCYC], e_en[NCYC], e_kill[NCYC], e_fw[NCYC], e_w[NCYC], e_fe[NCYC];
    bit          e_ill[NCYC], e_err[NCYC], e_chkex[NCYC], e_chkwb[NCYC];
    logic [4:0]  x_op[NCYC], x_waddr[NCYC], x_flg[NCYC], e_acc[NCYC];
    logic [2:0]  x_rm[NCYC];
    logic [31:0] x_a[NCYC], x_b[NCYC], x_c[NCYC], x_wdata[NCYC];

    int cyc = 0;
    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d actual=%h required=%h", nm, k, act, exp);
        end
    endtask

    function automatic logic [31:0] opnd(input int c, input int n);
        return 32'h1000_0000 * n + 32'(c);
    endfunction

    // lat: 0 = ready in the launch cycle, n = ready in n-th wait cycle, -1 = never.
    // fl: flush n cycles after launch (-1 = none).
    task automatic plan(input int c, input logic [4:0] op, input logic [2:0] rm, input logic [2:0] frm_v,
                        input bit fdest, input logic [4:0] waddr, input int lat, input int fl,
                        input logic [31:0] res, input logic [4:0] flg);
        logic [2:0] rr;
        int fin;
        d_valid[c] = 1'b1; d_op[c] = op; d_rm[c] = rm; d_frm[c] = frm_v;
        d_fdest[c] = fdest; d_waddr[c] = waddr;
        if (lat >= 0) begin
            d_rdy[c+1+lat] = 1'b1; d_res[c+1+lat] = res; d_flg[c+1+lat] = flg;
        end
        rr = (rm == 3'd7) ? frm_v : rm;
        if (rr == 3'd5 || rr == 3'd6) begin
            e_ill[c+1] = 1'b1;
            return;
        end
        e_en[c+1] = 1'b1; e_chkex[c+1] = 1'b1; x_op[c+1] = op; x_rm[c+1] = rr;
        x_a[c+1] = opnd(c, 1); x_b[c+1] = opnd(c, 2); x_c[c+1] = opnd(c, 3);
        if (fl >= 0 && (lat < 0 || fl <= lat)) begin
            fin = c + 1 + fl;
            d_flush[fin] = 1'b1; e_kill[fin] = 1'b1;
        end else if (lat >= 0 && lat <= TMO) begin
            fin = c + 1 + lat;
            e_fw[fin+1] = fdest;
            e_w[fin+1]  = !fdest && (waddr != 5'd0);
            e_fe[fin+1] = !(op inside {FSGNJ, FMV_F2I, FMV_I2F, FCLASS});
            e_chkwb[fin+1] = 1'b1;
            x_waddr[fin+1] = waddr; x_wdata[fin+1] = res; x_flg[fin+1] = flg;
        end else begin
            fin = c + 1 + TMO;
            e_kill[fin] = 1'b1; e_err[fin+1] = 1'b1;
        end
        for (int k = c + 1; k <= fin; k++) e_rdy[k] = 1'b0;
    endtask

    task automatic flush_wb(input int k);
        d_flush[k] = 1'b1;
        e_fw[k] = 1'b0; e_w[k] = 1'b0; e_fe[k] = 1'b0; e_chkwb[k] = 1'b0;
        d_valid[k] = 1'b1; d_op[k] = FMUL; d_rm[k] = 3'd0; d_waddr[k] = 5'd1; d_fdest[k] = 1'b1;
    endtask

    task automatic finalize();
        logic [4:0] acc;
        acc = 5'd0;
        for (int k = 0; k < NCYC; k++) begin
            if (d_flush[k]) e_rdy[k] = 1'b0;
`ifdef FPU_FFLAGS_ACCUM_EN
            e_acc[k] = acc;
`else
            e_acc[k] = 5'd0;
`endif
            if (d_clr[k]) acc = 5'd0;
            else if (e_fe[k]) acc = acc | x_flg[k];
        end
    endtask

    task automatic drive(input int k);
        req_valid = d_valid[k]; req_op = d_op[k]; req_rm = d_rm[k]; frm = d_frm[k];
        req_fdest = d_fdest[k]; req_waddr = d_waddr[k];
        req_data1 = opnd(k, 1); req_data2 = opnd(k, 2); req_data3 = opnd(k, 3);
        exe_ready = d_rdy[k];
        exe_result = d_rdy[k] ? d_res[k] : (32'hDEAD_0000 | 32'(k));
        exe_flags = d_rdy[k] ? d_flg[k] : 5'h1F;
        flush = d_flush[k]; acc_clear = d_clr[k];
    endtask

    task automatic compare(input int k);
        chk("req_ready", k, 32'(req_ready), 32'(e_rdy[k]));
        chk("exe_enable", k, 32'(exe_enable), 32'(e_en[k]));
        chk("exe_kill", k, 32'(exe_kill), 32'(e_kill[k]));
        chk("wb_fwren", k, 32'(wb_fwren), 32'(e_fw[k]));
        chk("wb_wren", k, 32'(wb_wren), 32'(e_w[k]));
        chk("wb_flag_en", k, 32'(wb_flag_en), 32'(e_fe[k]));
        chk("wb_illegal", k, 32'(wb_illegal), 32'(e_ill[k]));
        chk("wb_error", k, 32'(wb_error), 32'(e_err[k]));
        chk("acc_fflags", k, 32'(acc_fflags), 32'(e_acc[k]));
        if (e_chkex[k]) begin
            chk("exe_op", k, 32'(exe_op), 32'(x_op[k]));
            chk("exe_rm", k, 32'(exe_rm), 32'(x_rm[k]));
            chk("exe_data1", k, exe_data1, x_a[k]);
            chk("exe_data2", k, exe_data2, x_b[k]);
            chk("exe_data3", k, exe_data3, x_c[k]);
        end
        if (e_chkwb[k]) begin
            chk("wb_waddr", k, 32'(wb_waddr), 32'(x_waddr[k]));
            chk("wb_wdata", k, wb_wdata, x_wdata[k]);
            if (e_fe[k]) chk("wb_fflags", k, 32'(wb_fflags), 32'(x_flg[k]));
        end
    endtask

    always @(negedge clock) begin
        if (cyc >= 1 && cyc < NCYC) compare(cyc);
    end

    initial begin
        for (int k = 0; k < NCYC; k++) begin
            d_valid[k] = 0; d_fdest[k] = 0; d_rdy[k] = 0; d_flush[k] = 0; d_clr[k] = 0;
            d_op[k] = '0; d_waddr[k] = '0; d_flg[k] = '0; d_rm[k] = '0; d_frm[k] = '0; d_res[k] = '0;
            e_rdy[k] = 1; e_en[k] = 0; e_kill[k] = 0; e_fw[k] = 0; e_w[k] = 0; e_fe[k] = 0;
            e_ill[k] = 0; e_err[k] = 0; e_chkex[k] = 0; e_chkwb[k] = 0;
            x_op[k] = '0; x_waddr[k] = '0; x_flg[k] = '0; e_acc[k] = '0; x_rm[k] = '0;
            x_a[k] = '0; x_b[k] = '0; x_c[k] = '0; x_wdata[k] = '0;
        end
        //   cyc  op        rm    frm   fd  wa     lat  fl   result          flags
        plan(5,   FSGNJ,    3'd0, 3'd0, 1,  5'd3,  0,   -1,  32'h3F80_0000,  5'h01);
        plan(7,   FDIV,     3'd0, 3'd0, 1,  5'd5,  10,  -1,  32'h4000_0000,  5'h08);
        plan(19,  FCMP,     3'd0, 3'd0, 0,  5'd0,  0,   -1,  32'h0000_0001,  5'h10);
        plan(21,  FADD,     3'd7, 3'd6, 1,  5'd4,  -1,  -1,  32'h0,          5'h00);
        plan(22,  FMUL,     3'd5, 3'd0, 1,  5'd4,  -1,  -1,  32'h0,          5'h00);
        plan(25,  FMADD,    3'd0, 3'd0, 1,  5'd6,  -1,  -1,  32'h0,          5'h00);
        plan(93,  FMUL,     3'd7, 3'd2, 0,  5'd9,  2,   2,   32'h1234_5678,  5'h02);
        plan(98,  FSUB,     3'd1, 3'd0, 0,  5'd7,  2,   -1,  32'hCAFE_F00D,  5'h01);
        plan(104, FADD,     3'd0, 3'd0, 1,  5'd2,  0,   -1,  32'h0BAD_0BAD,  5'h01);
        flush_wb(106);
        d_clr[108] = 1'b1;
        plan(110, FADD,     3'd0, 3'd0, 1,  5'd4,  0,   -1,  32'h3F00_0000,  5'h01);
        plan(112, FSUB,     3'd0, 3'd0, 1,  5'd8,  0,   -1,  32'h3E00_0000,  5'h10);
        plan(114, FMUL,     3'd0, 3'd0, 1,  5'd9,  0,   -1,  32'h3D00_0000,  5'h04);
        d_clr[116] = 1'b1;
        finalize();

        // Hand-worked anchors for the model itself
        chk("pin_fsgnj_en", 6, 32'(e_en[6]), 32'd1);
        chk("pin_fsgnj_fw", 7, 32'(e_fw[7]), 32'd1);
        chk("pin_fsgnj_wa", 7, 32'(x_waddr[7]), 32'd3);
        chk("pin_fsgnj_wd", 7, x_wdata[7], 32'h3F80_0000);
        chk("pin_fsgnj_fe", 7, 32'(e_fe[7]), 32'd0);
        chk("pin_fdiv_fe", 19, 32'(e_fe[19]), 32'd1);
        chk("pin_fdiv_fl", 19, 32'(x_flg[19]), 32'h08);
        chk("pin_fcmp_w", 21, 32'(e_w[21] | e_fw[21]), 32'd0);
        chk("pin_ill_dyn", 22, 32'(e_ill[22]), 32'd1);
        chk("pin_ill_noen", 22, 32'(e_en[22]), 32'd0);
        chk("pin_tmo_kill", 90, 32'(e_kill[90]), 32'd1);
        chk("pin_tmo_err", 91, 32'(e_err[91]), 32'd1);
`ifdef FPU_FFLAGS_ACCUM_EN
        chk("pin_acc_or", 115, 32'(e_acc[115]), 32'h11);
        chk("pin_acc_clr", 117, 32'(e_acc[117]), 32'h00);
`endif

        while (cyc < NCYC - 1) begin
            @(posedge clock);
            cyc++;
            #1;
            if (cyc == 3) reset = 1'b0;
            drive(cyc);
        end
        @(negedge clock);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
